hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's combinational forwarding unit: tracks every in-flight register write in a DEPTH-entry shift-register scoreboard (EX, MEM, WB, …) and, for NRP ID-stage read ports, selects the youngest forwarding source or raises a load-use/multi-cycle stall. Each entry carries a per-instruction "ready stage", so ALU, load and longer-latency results share one mechanism. Sits between the decoder and the ID/EX register; drives the ID-stage bypass muxes and the PC/IF-ID hold.

---
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks in-flight register writes in a DEPTH-entry shift-register scoreboard
// (entry 0 = EX ... entry DEPTH-1 = WB). For each ID-stage read port it picks
// the youngest forwarding source, or flags a hazard when that source's result
// does not exist yet. A hazard on a port that consumes its operand stalls ID.
// Optional feature macro: HZD_STALL_CNT_EN (saturating stall-cycle counter).
module hazard_scoreboard #(
    parameter int NRP   = 4,
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int SELW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iss_we,
    input  logic [AW-1:0]        iss_waddr,
    input  logic [SELW-1:0]      iss_rdy,
    input  logic                 flush,
    input  logic [NRP*AW-1:0]    rd_addr,
    input  logic [NRP-1:0]       rd_use,
    output logic [NRP*SELW-1:0]  fwd_sel,
    output logic                 stall,
    output logic [31:0]          stall_cnt
);

    // Entry k describes the instruction k+1 stages past ID.
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_we;
    logic [AW-1:0]    ent_waddr [DEPTH];
    logic [SELW-1:0]  ent_rdy   [DEPTH];
    logic [NRP-1:0]   hazard;

    // Valid bits: reset clears the scoreboard; stall/flush inject a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
        end else begin
            ent_vld <= {ent_vld[DEPTH-2:0], ~(stall | flush)};
        end
    end

    // Payload fields shift unconditionally; a bubble is masked by its valid bit.
    always_ff @(posedge clk) begin
        ent_we[0]    <= iss_we;
        ent_waddr[0] <= iss_waddr;
        ent_rdy[0]   <= iss_rdy;
        for (int k = 1; k < DEPTH; k++) begin
            ent_we[k]    <= ent_we[k-1];
            ent_waddr[k] <= ent_waddr[k-1];
            ent_rdy[k]   <= ent_rdy[k-1];
        end
    end

    // Per-port match search; scanning oldest to youngest lets the youngest
    // match overwrite, so an older available copy never hides a younger one.
    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        for (int i = 0; i < NRP; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_vld[k] && ent_we[k] && (ent_waddr[k] != '0) &&
                    (ent_waddr[k] == rd_addr[i*AW +: AW])) begin
                    if (SELW'(k) >= ent_rdy[k]) begin
                        fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                        hazard[i]               = 1'b0;
                    end else begin
                        fwd_sel[i*SELW +: SELW] = '0;
                        hazard[i]               = 1'b1;
                    end
                end
            end
        end
        stall = |(hazard & rd_use);
    end

`ifdef HZD_STALL_CNT_EN
    logic [31:0] cnt;

    // Saturating count of stalled cycles; reset takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (stall && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: table-driven directed sequences followed by
// randomized traffic, all checked against an issue-history reference model.
module tb_hazard_scoreboard;
    localparam int NRP   = 4;
    localparam int DEPTH = 3;
    localparam int AW    = 5;
    localparam int SELW  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                iss_we;
    logic [AW-1:0]       iss_waddr;
    logic [SELW-1:0]     iss_rdy;
    logic                flush;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP-1:0]      rd_use;
    logic [NRP*SELW-1:0] fwd_sel;
    logic                stall;
    logic [31:0]         stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NRP(NRP), .DEPTH(DEPTH), .AW(AW), .SELW(SELW)) dut (
        .clk(clk), .rst(rst), .iss_we(iss_we), .iss_waddr(iss_waddr),
        .iss_rdy(iss_rdy), .flush(flush), .rd_addr(rd_addr), .rd_use(rd_use),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic                r;
        logic                we;
        logic [AW-1:0]       wa;
        logic [SELW-1:0]     rdy;
        logic                fl;
        logic [NRP*AW-1:0]   ra;
        logic [NRP-1:0]      ru;
        logic [NRP*SELW-1:0] esel;
        logic                est;
    } vec_t;

    // One record per issued register write, stamped with its issue cycle.
    typedef struct {
        int            cyc;
        logic [AW-1:0] wa;
        int            rdy;
    } wr_t;

    vec_t        tbl[$];
    wr_t         hist[$];
    int          now;
    logic [31:0] exp_cnt;
    int          n_chk;
    int          n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, now, act, exp);
        end
    endtask

    // A write issued `age` cycles ago sits at entry age-1; its result exists
    // once age-1 >= rdy. The youngest matching write decides the port.
    function automatic void model(input logic [NRP*AW-1:0] ra, input logic [NRP-1:0] ru,
                                  output logic [NRP*SELW-1:0] sel, output logic st);
        sel = '0;
        st  = 1'b0;
        for (int i = 0; i < NRP; i++) begin
            int best_age;
            int best_rdy;
            best_age = 0;
            best_rdy = 0;
            foreach (hist[j]) begin
                int age;
                age = now - hist[j].cyc;
                if (age >= 1 && age <= DEPTH && hist[j].wa != '0 &&
                    hist[j].wa == ra[i*AW +: AW] && (best_age == 0 || age < best_age)) begin
                    best_age = age;
                    best_rdy = hist[j].rdy;
                end
            end
            if (best_age != 0) begin
                if (best_age - 1 >= best_rdy) sel[i*SELW +: SELW] = SELW'(best_age);
                else if (ru[i]) st = 1'b1;
            end
        end
    endfunction

    task automatic run(input vec_t v, input bit use_tbl);
        logic [NRP*SELW-1:0] msel;
        logic                mst;
        rst       = v.r;
        iss_we    = v.we;
        iss_waddr = v.wa;
        iss_rdy   = v.rdy;
        flush     = v.fl;
        rd_addr   = v.ra;
        rd_use    = v.ru;
        @(negedge clk);
        model(v.ra, v.ru, msel, mst);
        check("model_fwd_sel", 32'(fwd_sel), 32'(msel));
        check("model_stall", 32'(stall), 32'(mst));
`ifdef HZD_STALL_CNT_EN
        check("stall_cnt", stall_cnt, exp_cnt);
`else
        check("stall_cnt", stall_cnt, 32'd0);
`endif
        if (use_tbl) begin
            check("tbl_fwd_sel", 32'(fwd_sel), 32'(v.esel));
            check("tbl_stall", 32'(stall), 32'(v.est));
        end
        @(posedge clk);
        if (v.r) begin
            hist.delete();
            exp_cnt = '0;
        end else begin
            if (mst && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            if (!mst && !v.fl && v.we) hist.push_back('{now, v.wa, int'(v.rdy)});
        end
        now++;
        while (hist.size() > 0 && now - hist[0].cyc > DEPTH) void'(hist.pop_front());
        #1;
    endtask

    function automatic logic [NRP*AW-1:0] ra4(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NRP*SELW-1:0] fs4(input int s0, input int s1, input int s2, input int s3);
        return {SELW'(s3), SELW'(s2), SELW'(s1), SELW'(s0)};
    endfunction

    function automatic vec_t mk(input int r, input int we, input int wa, input int rdy, input int fl,
                                input logic [NRP*AW-1:0] ra, input int ru,
                                input logic [NRP*SELW-1:0] esel, input int est);
        vec_t v;
        v.r = 1'(r); v.we = 1'(we); v.wa = AW'(wa); v.rdy = SELW'(rdy); v.fl = 1'(fl);
        v.ra = ra; v.ru = NRP'(ru); v.esel = esel; v.est = 1'(est);
        return v;
    endfunction

    initial begin
        vec_t v;
        n_chk = 0; n_fail = 0; now = 0; exp_cnt = '0;
        rst = 1'b1; iss_we = 1'b0; iss_waddr = '0; iss_rdy = '0; flush = 1'b0;
        rd_addr = '0; rd_use = '0;
        repeat (2) @(posedge clk);
        #1;

        // ALU write r8 then reads at EX, MEM, WB, retired
        tbl.push_back(mk(0, 1, 8, 0, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(8,0,0,0), 4'b0001, fs4(1,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(8,0,0,0), 4'b0001, fs4(2,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(8,0,0,0), 4'b0001, fs4(3,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(8,0,0,0), 4'b0001, fs4(0,0,0,0), 0));
        // load-use: one stall, then forward from MEM
        tbl.push_back(mk(0, 1, 9, 1, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,9,0,0), 4'b0010, fs4(0,0,0,0), 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,9,0,0), 4'b0010, fs4(0,2,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        // older ALU r5, younger load r5: younger unavailable wins
        tbl.push_back(mk(0, 1, 5, 0, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 1, 5, 1, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,5,0), 4'b0100, fs4(0,0,0,0), 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,5,0), 4'b0100, fs4(0,0,2,0), 0));
        // writes to r0 never forward or stall
        tbl.push_back(mk(0, 1, 0, 0, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,0,0), 4'b1111, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,0,0), 4'b1111, fs4(0,0,0,0), 0));
        // flushed load is invisible; unused operand never stalls
        tbl.push_back(mk(0, 1, 4, 1, 1, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(4,0,0,0), 4'b0001, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 1, 4, 1, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,0,4), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        // rdy=2 producer; reset during the second stall cycle
        tbl.push_back(mk(0, 1, 7, 2, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(7,0,0,0), 4'b0001, fs4(0,0,0,0), 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, ra4(7,0,0,0), 4'b0001, fs4(0,0,0,0), 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, ra4(7,0,0,0), 4'b0001, fs4(0,0,0,0), 0));

        foreach (tbl[i]) run(tbl[i], 1'b1);

        // rdy=2 with immediate dependent: exactly two stall cycles, then entry 2
        run(mk(0, 1, 3, 2, 0, ra4(0,0,0,0), 4'b0000, fs4(0,0,0,0), 0), 1'b1);
        run(mk(0, 0, 0, 0, 0, ra4(0,3,0,0), 4'b0010, fs4(0,0,0,0), 1), 1'b1);
        run(mk(0, 0, 0, 0, 0, ra4(0,3,0,0), 4'b0010, fs4(0,0,0,0), 1), 1'b1);
        run(mk(0, 0, 0, 0, 0, ra4(0,3,0,0), 4'b0010, fs4(0,3,0,0), 0), 1'b1);

        for (int n = 0; n < 400; n++) begin
            v.r    = 1'($urandom_range(63) == 0);
            v.we   = 1'($urandom);
            v.wa   = AW'($urandom_range(7));
            v.rdy  = SELW'($urandom_range(DEPTH - 1));
            v.fl   = 1'($urandom_range(7) == 0);
            for (int i = 0; i < NRP; i++) v.ra[i*AW +: AW] = AW'($urandom_range(7));
            v.ru   = NRP'($urandom);
            v.esel = '0;
            v.est  = 1'b0;
            run(v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
